// File: rtl/fir_pkg.sv
// fir_pkg: constants and FSM state type shared by the FIR filter and its DA LUT loader.
//   N_TAPS  number of filter taps
//   COEF_W  signed coefficient width
//   GRP     taps per distributed-arithmetic group (2**GRP LUT entries per group)
//   LUT_W   LUT entry width (signed)
//   ADDR_W  LUT address width; (N_TAPS/GRP)*2**GRP == 2**ADDR_W
package fir_pkg;

  localparam int unsigned N_TAPS = 64;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned GRP    = 8;
  localparam int unsigned LUT_W  = 20;
  localparam int unsigned ADDR_W = 11;

  localparam int unsigned TAP_W  = $clog2(N_TAPS);
  localparam int unsigned GRP_W  = $clog2(GRP);
  // Address bits that select the tap group (k); the low GRP bits are the mask (m).
  localparam int unsigned KSEL_W = ADDR_W - GRP;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOAD,
    DONE
  } fir_state_e;

endpackage

// File: rtl/dalut_psum.sv
// dalut_psum: combinational DA partial sum for one tap group.
//   coef_grp  in   GRP signed coefficients of the selected group
//   mask      in   GRP-bit selection mask; bit b includes coef_grp[b]
//   psum      out  LUT_W signed sum of the selected coefficients
module dalut_psum
  import fir_pkg::*;
(
  input  logic signed [COEF_W-1:0] coef_grp [GRP],
  input  logic        [GRP-1:0]    mask,
  output logic signed [LUT_W-1:0]  psum
);

  // GRP full-scale coefficients fit in LUT_W bits, so the sum never overflows.
  always_comb begin
    psum = '0;
    for (int b = 0; b < GRP; b++) begin
      if (mask[b]) begin
        psum = psum + {{(LUT_W - COEF_W){coef_grp[b][COEF_W-1]}}, coef_grp[b]};
      end
    end
  end

endmodule

// File: rtl/dalut_loader.sv
// dalut_loader: collects N_TAPS signed coefficients over a valid/ready stream, then
// computes and streams all 2**ADDR_W distributed-arithmetic LUT entries into the filter's
// LUT port, one entry per clock.
//   clk_slow    in   LUT-load clock
//   resetn      in   asynchronous active-low reset
//   start       in   1-cycle pulse; begins coefficient collection (ignored while busy)
//   coef_in     in   signed coefficient, tap order 0..N_TAPS-1
//   coef_valid  in   coef_in valid
//   coef_ready  out  coefficient accepted when valid & ready
//   CIN         out  LUT entry data
//   CADDR       out  LUT entry address
//   CLOAD       out  LUT write strobe
//   busy        out  high from accepted start through the done pulse
//   done        out  1-cycle pulse after the last LUT write
//   cksum       out  (only with DALUT_CKSUM_EN) running sum of sign-extended CIN writes
// Build option: define DALUT_CKSUM_EN to add the cksum output and its accumulator.
module dalut_loader
  import fir_pkg::*;
(
  input  logic              clk_slow,
  input  logic              resetn,
  input  logic              start,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [LUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
`ifdef DALUT_CKSUM_EN
  ,
  output logic [31:0]       cksum
`endif
);

  fir_state_e               state_q, state_d;
  logic       [TAP_W-1:0]   tap_q, tap_d;
  logic       [ADDR_W-1:0]  cnt_q, cnt_d;
  logic signed [COEF_W-1:0] coef_q [N_TAPS];
  logic                     coef_we;
  logic                     start_acc;

  logic       [LUT_W-1:0]   cin_q, cin_d;
  logic       [ADDR_W-1:0]  caddr_q, caddr_d;
  logic                     cload_q, cload_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [COEF_W-1:0] coef_grp [GRP];
  logic signed [LUT_W-1:0]  psum;
  logic       [KSEL_W-1:0]  grp_sel;

  // Group select k comes from the top address bits; mask m from the low GRP bits.
  assign grp_sel = cnt_q[ADDR_W-1 -: KSEL_W];

  always_comb begin
    for (int b = 0; b < GRP; b++) begin
      coef_grp[b] = coef_q[{grp_sel, GRP_W'(b)}];
    end
  end

  dalut_psum u_psum (
    .coef_grp (coef_grp),
    .mask     (cnt_q[GRP-1:0]),
    .psum     (psum)
  );

  // busy_q also covers the done cycle, so a start coinciding with done is dropped.
  assign start_acc = (state_q == IDLE) && !busy_q && start;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    caddr_d = caddr_q;
    cload_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    coef_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (start_acc) begin
          state_d = COLLECT;
          busy_d  = 1'b1;
          tap_d   = '0;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (coef_valid) begin
          coef_we = 1'b1;
          tap_d   = tap_q + 1'b1;
          if (tap_q == TAP_W'(N_TAPS - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        cload_d = 1'b1;
        caddr_d = cnt_q;
        cin_d   = psum;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Last write is on the port this cycle; done follows on the next one.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= '0;
      caddr_q <= '0;
      cload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      caddr_q <= caddr_d;
      cload_q <= cload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (coef_we) begin
        coef_q[tap_q] <= coef_in;
      end
    end
  end

  assign coef_ready = (state_q == COLLECT);
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;
  assign CLOAD      = cload_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef DALUT_CKSUM_EN
  logic [31:0] cksum_q;

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      cksum_q <= '0;
    end else if (start_acc) begin
      cksum_q <= '0;
    end else if (cload_q) begin
      cksum_q <= cksum_q + {{(32 - LUT_W){cin_q[LUT_W-1]}}, cin_q};
    end
  end

  assign cksum = cksum_q;
`endif

endmodule
